// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 3-column x 4-row active-low keypad, debounces the key found and
// emits one single-cycle 3-bit key code per press. Define KEYPAD_REPEAT_EN for auto-repeat.
module keypad_scanner #(
  parameter logic [3:0]  SCAN_CYCLES    = 4'd8,
  parameter logic [15:0] DEBOUNCE_COUNT = 16'd1000,
  parameter logic [23:0] REPEAT_CYCLES  = 24'd500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [2:0] col,
  output logic [2:0] kp_out,
  output logic       kp_valid,
  output logic       key_held
);

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEBOUNCE,
    S_HELD,
    S_RELEASE
  } state_t;

  localparam logic [3:0] SCAN_LAST = SCAN_CYCLES - 4'd1;
  localparam logic [3:0] ROWS_IDLE = 4'b1111;

  // The synchronizer needs two cycles, so a window shorter than three never sees its own rows.
  if (SCAN_CYCLES < 4'd3) begin : g_chk_scan
    $error("keypad_scanner: SCAN_CYCLES must be at least 3");
  end
  if (DEBOUNCE_COUNT == 16'd0) begin : g_chk_debounce
    $error("keypad_scanner: DEBOUNCE_COUNT must be nonzero");
  end
  if (REPEAT_CYCLES == 24'd0) begin : g_chk_repeat
    $error("keypad_scanner: REPEAT_CYCLES must be nonzero");
  end

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

`ifdef KEYPAD_REPEAT_EN
  function automatic logic [23:0] sat_inc24(input logic [23:0] v);
    return (v == 24'hFFFFFF) ? v : v + 24'd1;
  endfunction
`endif

  function automatic logic [1:0] next_col(input logic [1:0] c);
    return (c == 2'd2) ? 2'd0 : c + 2'd1;
  endfunction

  // Returns 3'b000 for unmapped keys and for patterns with more than one row low.
  function automatic logic [2:0] key_code(input logic [3:0] rows_n, input logic [1:0] c);
    logic [2:0] kc;
    case ({rows_n, c})
      {4'b1110, 2'd0}: kc = 3'b001;
      {4'b1110, 2'd1}: kc = 3'b010;
      {4'b1110, 2'd2}: kc = 3'b011;
      {4'b1101, 2'd0}: kc = 3'b100;
      {4'b1101, 2'd1}: kc = 3'b101;
      {4'b0111, 2'd0}: kc = 3'b110;
      {4'b0111, 2'd2}: kc = 3'b111;
      default:         kc = 3'b000;
    endcase
    return kc;
  endfunction

  state_t      state, state_nxt;
  logic [1:0]  col_idx, col_idx_nxt;
  logic [3:0]  scan_cnt, scan_cnt_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [3:0]  row_p0, rs;
  logic [3:0]  lat_row, lat_row_nxt;
  logic [2:0]  lat_code, lat_code_nxt;
  logic [2:0]  kp_out_nxt;
  logic        kp_valid_nxt;
  logic [2:0]  scan_code;
`ifdef KEYPAD_REPEAT_EN
  logic [23:0] rep_cnt, rep_cnt_nxt;
`endif

  assign scan_code = key_code(rs, col_idx);
  assign key_held  = (state == S_HELD) || (state == S_RELEASE);

  always_comb begin
    case (col_idx)
      2'd1:    col = 3'b101;
      2'd2:    col = 3'b011;
      default: col = 3'b110;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    col_idx_nxt  = col_idx;
    scan_cnt_nxt = scan_cnt;
    cnt_nxt      = cnt;
    lat_row_nxt  = lat_row;
    lat_code_nxt = lat_code;
    kp_valid_nxt = 1'b0;
    kp_out_nxt   = 3'b000;
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_nxt  = 24'd0;
`endif
    unique case (state)
      S_SCAN: begin
        if (scan_cnt == SCAN_LAST) begin
          scan_cnt_nxt = 4'd0;
          if (scan_code != 3'b000) begin
            state_nxt    = S_DEBOUNCE;
            lat_row_nxt  = rs;
            lat_code_nxt = scan_code;
            cnt_nxt      = 16'd0;
          end else begin
            col_idx_nxt = next_col(col_idx);
          end
        end else begin
          scan_cnt_nxt = scan_cnt + 4'd1;
        end
      end
      S_DEBOUNCE: begin
        if (cnt == DEBOUNCE_COUNT) begin
          state_nxt    = S_HELD;
          kp_valid_nxt = 1'b1;
          kp_out_nxt   = lat_code;
        end else if (rs == lat_row) begin
          cnt_nxt = sat_inc16(cnt);
        end else begin
          state_nxt    = S_SCAN;
          col_idx_nxt  = next_col(col_idx);
          scan_cnt_nxt = 4'd0;
        end
      end
      S_HELD: begin
        // Only a full release matters here; extra keys in the frozen column are ignored.
        if (rs == ROWS_IDLE) begin
          state_nxt = S_RELEASE;
          cnt_nxt   = 16'd0;
        end
`ifdef KEYPAD_REPEAT_EN
        else if (rep_cnt == REPEAT_CYCLES) begin
          kp_valid_nxt = 1'b1;
          kp_out_nxt   = lat_code;
        end else begin
          rep_cnt_nxt = sat_inc24(rep_cnt);
        end
`endif
      end
      S_RELEASE: begin
        if (cnt == DEBOUNCE_COUNT) begin
          state_nxt    = S_SCAN;
          col_idx_nxt  = next_col(col_idx);
          scan_cnt_nxt = 4'd0;
          cnt_nxt      = 16'd0;
        end else if (rs == ROWS_IDLE) begin
          cnt_nxt = sat_inc16(cnt);
        end else begin
          state_nxt = S_HELD;
        end
      end
      default: state_nxt = S_SCAN;
    endcase
  end

  // Row synchronizer and latched key: data only, no reset needed.
  always_ff @(posedge clk) begin
    row_p0   <= row;
    rs       <= row_p0;
    lat_row  <= lat_row_nxt;
    lat_code <= lat_code_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_SCAN;
      col_idx  <= 2'd0;
      scan_cnt <= 4'd0;
      cnt      <= 16'd0;
      kp_valid <= 1'b0;
      kp_out   <= 3'b000;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt  <= 24'd0;
`endif
    end else begin
      state    <= state_nxt;
      col_idx  <= col_idx_nxt;
      scan_cnt <= scan_cnt_nxt;
      cnt      <= cnt_nxt;
      kp_valid <= kp_valid_nxt;
      kp_out   <= kp_out_nxt;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt  <= rep_cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner: keypad matrix model, pulse monitor and scenario tasks.
// Run with and without KEYPAD_REPEAT_EN defined.
module tb_keypad_scanner;

  localparam int SC  = 4;
  localparam int DBC = 8;
`ifdef KEYPAD_REPEAT_EN
  localparam int EXP_HOLD150_PULSES = 4;
`else
  localparam int EXP_HOLD150_PULSES = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] row;
  logic [2:0] col;
  logic [2:0] kp_out;
  logic       kp_valid;
  logic       key_held;

  logic [11:0] keys = 12'd0;   // bit r*3+c set = key (r,c) pressed

  int tests_run = 0;
  int tests_failed = 0;

  int          pulse_cnt = 0;
  logic [2:0]  pulse_codes[$];
  int          consec_viol = 0;
  int          out_viol = 0;
  int          col_viol = 0;
  logic        mon_en = 1'b0;
  logic        prev_v = 1'b0;

  keypad_scanner #(
    .SCAN_CYCLES   (4'd4),
    .DEBOUNCE_COUNT(16'd8),
    .REPEAT_CYCLES (24'd40)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .row     (row),
    .col     (col),
    .kp_out  (kp_out),
    .kp_valid(kp_valid),
    .key_held(key_held)
  );

  always #5 clk = ~clk;

  // Passive matrix: a row reads low when a pressed key in it sits on the driven column.
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (keys[r*3+c] && (col[c] === 1'b0)) row[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (kp_valid) begin
        pulse_codes.push_back(kp_out);
        pulse_cnt = pulse_cnt + 1;
      end
      if (kp_valid && prev_v) consec_viol = consec_viol + 1;
      if (!kp_valid && kp_out !== 3'b000) out_viol = out_viol + 1;
      if (col !== 3'b110 && col !== 3'b101 && col !== 3'b011) col_viol = col_viol + 1;
      prev_v = kp_valid;
    end
  end

  function automatic logic [2:0] kmap(input int idx);
    case (idx)
      0:  return 3'b001;
      1:  return 3'b010;
      2:  return 3'b011;
      3:  return 3'b100;
      4:  return 3'b101;
      9:  return 3'b110;
      11: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] col_pat(input int i);
    case (i)
      0: return 3'b110;
      1: return 3'b101;
      default: return 3'b011;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench at the negedge of the first cycle a column is driven.
  task automatic wait_fresh_col(input logic [2:0] target);
    logic [2:0] prv;
    bit ok;
    ok = 0;
    prv = col;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (col === target && prv !== target) ok = 1;
      prv = col;
    end
    if (!ok) begin
      tests_run++; tests_failed++;
      $display("FAIL wait_col: col=%b required=%b", col, target);
    end
  endtask

  task automatic test_reset;
    bit any_v;
    reset = 1'b0;
    keys = 12'd0;
    @(negedge clk);
    tick(2);
    tests_run++;
    if (col !== 3'b110) begin tests_failed++; $display("FAIL reset_col: got %b required 110", col); end
    tests_run++;
    if (kp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b required 0", kp_valid); end
    tests_run++;
    if (kp_out !== 3'b000) begin tests_failed++; $display("FAIL reset_kp_out: got %b required 000", kp_out); end
    tests_run++;
    if (key_held !== 1'b0) begin tests_failed++; $display("FAIL reset_held: got %b required 0", key_held); end
    reset = 1'b1;
    mon_en = 1'b1;
    any_v = 0;
    for (int n = 1; n <= 24; n++) begin
      tick(1);
      if (kp_valid) any_v = 1;
      tests_run++;
      if (col !== col_pat((n / SC) % 3)) begin
        tests_failed++;
        $display("FAIL scan_rotate[%0d]: got %b required %b", n, col, col_pat((n / SC) % 3));
      end
    end
    tests_run++;
    if (any_v) begin tests_failed++; $display("FAIL idle_no_pulse: got pulse required none"); end
  endtask

  task automatic test_single_press;
    int base;
    int frozen_bad;
    wait_fresh_col(3'b101);
    base = pulse_cnt;
    keys = 12'd0; keys[1] = 1'b1;
    tick(12);
    tests_run++;
    if (kp_valid !== 1'b0) begin tests_failed++; $display("FAIL press_early: got valid=%b required 0", kp_valid); end
    tick(1);
    tests_run++;
    if (kp_valid !== 1'b1 || kp_out !== 3'b010) begin
      tests_failed++; $display("FAIL press_pulse: got valid=%b code=%b required 1/010", kp_valid, kp_out);
    end
    frozen_bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (col !== 3'b101 || key_held !== 1'b1) frozen_bad++;
    end
    tests_run++;
    if (frozen_bad != 0) begin tests_failed++; $display("FAIL held_frozen: got %0d bad cycles required 0", frozen_bad); end
    tests_run++;
    if (pulse_cnt - base != 1) begin tests_failed++; $display("FAIL press_count: got %0d required 1", pulse_cnt - base); end
    keys = 12'd0;
    tick(2 + 1 + DBC);
    tests_run++;
    if (key_held !== 1'b1) begin tests_failed++; $display("FAIL release_early: got held=%b required 1", key_held); end
    tick(1);
    tests_run++;
    if (key_held !== 1'b0 || col !== 3'b011) begin
      tests_failed++; $display("FAIL release_resume: got held=%b col=%b required 0/011", key_held, col);
    end
  endtask

  task automatic test_bounce;
    int base;
    wait_fresh_col(3'b101);
    base = pulse_cnt;
    keys = 12'd0; keys[1] = 1'b1;
    tick(6);
    keys[1] = 1'b0;
    tick(3);
    tests_run++;
    if (col !== 3'b011 || key_held !== 1'b0) begin
      tests_failed++; $display("FAIL bounce_resume: got col=%b held=%b required 011/0", col, key_held);
    end
    for (int i = 0; i < 6; i++) begin
      keys[1] = 1'b1; tick(3);
      keys[1] = 1'b0; tick(3);
    end
    tick(30);
    tests_run++;
    if (pulse_cnt != base) begin tests_failed++; $display("FAIL bounce_no_pulse: got %0d required 0", pulse_cnt - base); end
  endtask

  task automatic test_multi_key;
    int  base;
    int  a, b;
    bit  got;
    base = pulse_cnt;
    keys = 12'd0; keys[3] = 1'b1; keys[9] = 1'b1;
    tick(60);
    tests_run++;
    if (pulse_cnt != base || key_held !== 1'b0) begin
      tests_failed++; $display("FAIL multi_ignored: got pulses=%0d held=%b required 0/0", pulse_cnt - base, key_held);
    end
    keys = 12'd0;
    tick(20);
    base = pulse_cnt;
    keys[11] = 1'b1;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin tick(1); if (pulse_cnt != base) got = 1; end
    tests_run++;
    if (!got) begin tests_failed++; $display("FAIL hash_timeout: got no pulse required 1"); end
    else begin
      tests_run++;
      if (pulse_codes[pulse_codes.size()-1] !== 3'b111) begin
        tests_failed++; $display("FAIL hash_code: got %b required 111", pulse_codes[pulse_codes.size()-1]);
      end
    end
    keys = 12'd0;
    tick(30);
    a = 0;
    case ($urandom_range(0, 6))
      0: a = 0; 1: a = 1; 2: a = 2; 3: a = 3; 4: a = 4; 5: a = 9; default: a = 11;
    endcase
    b = (a + $urandom_range(1, 11)) % 12;
    base = pulse_cnt;
    keys[a] = 1'b1;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin tick(1); if (pulse_cnt != base) got = 1; end
    tests_run++;
    if (!got) begin tests_failed++; $display("FAIL first_key_timeout: key %0d got no pulse required 1", a); end
    keys[b] = 1'b1;
    tick(20);
    keys = 12'd0;
    tick(30);
    tests_run++;
    if (pulse_cnt - base != 1) begin
      tests_failed++; $display("FAIL first_key_wins: keys %0d+%0d got %0d pulses required 1", a, b, pulse_cnt - base);
    end
    tests_run++;
    if (pulse_codes[pulse_codes.size()-1] !== kmap(a)) begin
      tests_failed++; $display("FAIL first_key_code: got %b required %b", pulse_codes[pulse_codes.size()-1], kmap(a));
    end
  endtask

  task automatic test_reset_mid_debounce;
    int base;
    wait_fresh_col(3'b101);
    base = pulse_cnt;
    keys = 12'd0; keys[1] = 1'b1;
    tick(4 + 5);
    reset = 1'b0;
    tick(1);
    tests_run++;
    if (col !== 3'b110 || kp_valid !== 1'b0 || key_held !== 1'b0) begin
      tests_failed++; $display("FAIL mid_reset: got col=%b valid=%b held=%b required 110/0/0", col, kp_valid, key_held);
    end
    reset = 1'b1;
    keys = 12'd0;
    tick(40);
    tests_run++;
    if (pulse_cnt != base) begin tests_failed++; $display("FAIL mid_reset_pulse: got %0d required 0", pulse_cnt - base); end
  endtask

  task automatic test_repeat;
    int base;
    int bad;
    wait_fresh_col(3'b101);
    base = pulse_cnt;
    pulse_codes.delete();
    keys = 12'd0; keys[1] = 1'b1;
    tick(13);
    tests_run++;
    if (kp_valid !== 1'b1) begin tests_failed++; $display("FAIL repeat_accept: got valid=%b required 1", kp_valid); end
    tick(150);
    keys = 12'd0;
    tick(30);
    tests_run++;
    if (pulse_cnt - base != EXP_HOLD150_PULSES) begin
      tests_failed++; $display("FAIL repeat_count: got %0d required %0d", pulse_cnt - base, EXP_HOLD150_PULSES);
    end
    bad = 0;
    foreach (pulse_codes[i]) if (pulse_codes[i] !== 3'b010) bad++;
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("FAIL repeat_code: got %0d wrong codes required 0", bad); end
  endtask

  task automatic test_random_presses;
    int r, c, idx, hold, base;
    logic [2:0] exp;
    for (int it = 0; it < 10; it++) begin
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 2);
      idx = r * 3 + c;
      exp = kmap(idx);
      hold = 30 + $urandom_range(0, 8);
      base = pulse_cnt;
      keys = 12'd0; keys[idx] = 1'b1;
      tick(28);
      tests_run++;
      if (key_held !== (exp != 3'b000)) begin
        tests_failed++; $display("FAIL rand_held[%0d]: key (%0d,%0d) got %b required %b", it, r, c, key_held, exp != 3'b000);
      end
      tick(hold - 28);
      keys = 12'd0;
      tick(25);
      tests_run++;
      if (pulse_cnt - base != ((exp != 3'b000) ? 1 : 0)) begin
        tests_failed++; $display("FAIL rand_count[%0d]: key (%0d,%0d) got %0d required %0d", it, r, c,
                                 pulse_cnt - base, (exp != 3'b000) ? 1 : 0);
      end else if (exp != 3'b000) begin
        tests_run++;
        if (pulse_codes[pulse_codes.size()-1] !== exp) begin
          tests_failed++; $display("FAIL rand_code[%0d]: got %b required %b", it, pulse_codes[pulse_codes.size()-1], exp);
        end
      end
    end
  endtask

  task automatic test_invariants;
    tests_run++;
    if (consec_viol != 0) begin tests_failed++; $display("FAIL back_to_back_valid: got %0d required 0", consec_viol); end
    tests_run++;
    if (out_viol != 0) begin tests_failed++; $display("FAIL kp_out_idle: got %0d nonzero cycles required 0", out_viol); end
    tests_run++;
    if (col_viol != 0) begin tests_failed++; $display("FAIL col_onehot: got %0d bad cycles required 0", col_viol); end
  endtask

  initial begin
    test_reset;
    test_single_press;
    test_bounce;
    test_multi_key;
    test_reset_mid_debounce;
    test_repeat;
    test_random_presses;
    test_invariants;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
